// File: rtl/act_pipe_pkg.sv
// Shared types and fixed-point constants for the activation pipeline.
// act_func       : activation selector carried with each transaction.
// pwl_seg_e      : piecewise-linear sigmoid segment index (S1 -> S2).
// sig_b*/sig_off*: segment boundaries and offsets, exact for FRAC >= 5.
// pwl_classify   : maps a magnitude onto its sigmoid segment.
package act_pipe_pkg;

    typedef enum logic [1:0] {
        ACT_SIGMOID = 2'd0,
        ACT_TANH    = 2'd1,
        ACT_RELU    = 2'd2,
        ACT_STEP    = 2'd3
    } act_func;

    typedef enum logic [1:0] {
        SEG_LOW  = 2'd0,   // a < 1.0
        SEG_MID  = 2'd1,   // 1.0 <= a < 2.375
        SEG_HIGH = 2'd2,   // 2.375 <= a < 5.0
        SEG_SAT  = 2'd3    // a >= 5.0
    } pwl_seg_e;

    function automatic int unsigned sfp_one(input int frac);
        return 32'd1 << frac;
    endfunction

    // Segment boundaries: 1.0, 2.375 (19/8), 5.0
    function automatic int unsigned sig_b1(input int frac);
        return 32'd1 << frac;
    endfunction

    function automatic int unsigned sig_b2(input int frac);
        return 32'd19 << (frac - 3);
    endfunction

    function automatic int unsigned sig_b3(input int frac);
        return 32'd5 << frac;
    endfunction

    // Segment offsets: 0.5, 0.625 (5/8), 0.84375 (27/32)
    function automatic int unsigned sig_off0(input int frac);
        return 32'd1 << (frac - 1);
    endfunction

    function automatic int unsigned sig_off1(input int frac);
        return 32'd5 << (frac - 3);
    endfunction

    function automatic int unsigned sig_off2(input int frac);
        return 32'd27 << (frac - 5);
    endfunction

    function automatic pwl_seg_e pwl_classify(input logic [31:0] a, input int frac);
        if (a >= sig_b3(frac))      return SEG_SAT;
        else if (a >= sig_b2(frac)) return SEG_HIGH;
        else if (a >= sig_b1(frac)) return SEG_MID;
        else                        return SEG_LOW;
    endfunction

endpackage

// File: rtl/act_pipe_pwl_sigmoid_lane.sv
// pwl_sigmoid_lane: combinational piecewise-linear sigmoid for one lane.
// a   : magnitude |x| (AW bits, unsigned fixed point with FRAC fraction bits)
// neg : sign of the original operand
// seg : segment index for a, precomputed in the previous stage
// y   : sigmoid approximation in [0, ONE]
// sat : set when the approximation is clamped at ONE (or 0 for negative x)
module pwl_sigmoid_lane
    import act_pipe_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int AW    = WIDTH + 1
) (
    input  logic [AW-1:0]    a,
    input  logic             neg,
    input  pwl_seg_e         seg,
    output logic [WIDTH-1:0] y,
    output logic             sat
);

    localparam int IW = WIDTH + 2;
    localparam logic [IW-1:0] ONE  = IW'(sfp_one(FRAC));
    localparam logic [IW-1:0] OFF0 = IW'(sig_off0(FRAC));
    localparam logic [IW-1:0] OFF1 = IW'(sig_off1(FRAC));
    localparam logic [IW-1:0] OFF2 = IW'(sig_off2(FRAC));

    logic [IW-1:0] a_ext;
    logic [IW-1:0] mag;
    logic [IW-1:0] res;

    assign a_ext = IW'(a);

    always_comb begin
        mag = '0;
        sat = 1'b0;
        case (seg)
            SEG_SAT: begin
                mag = ONE;
                sat = 1'b1;
            end
            SEG_HIGH: mag = (a_ext >> 5) + OFF2;
            SEG_MID:  mag = (a_ext >> 3) + OFF1;
            default:  mag = (a_ext >> 2) + OFF0;
        endcase
        // Sigmoid symmetry: s(-x) = 1 - s(x)
        res = neg ? (ONE - mag) : mag;
        y   = WIDTH'(res);
    end

endmodule

// File: rtl/act_pipe.sv
// act_pipe: LANES-wide two-stage activation pipeline with valid/ready.
// clk, rst          : clock (rising edge), asynchronous active-high reset
// in_valid/in_ready : input handshake; in_ready depends on out_ready
// in_act            : activation for the whole transaction
// in_sum            : LANES signed sums, lane i at [i*WIDTH +: WIDTH]
// out_valid/out_ready: output handshake
// out_pred          : LANES signed results, same packing as in_sum
// out_sat           : per-lane saturation flag (Sigmoid/Tanh only)
module act_pipe
    import act_pipe_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  act_func                in_act,
    input  logic [LANES*WIDTH-1:0] in_sum,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_pred,
    output logic [LANES-1:0]       out_sat
);

    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(sfp_one(FRAC));
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};

    logic s1_valid;
    logic s2_valid;
    logic s2_load;

    // Stage 1 state
    act_func          s1_act;
    logic [WIDTH:0]   s1_a   [LANES];
    logic [LANES-1:0] s1_neg;
    pwl_seg_e         s1_seg [LANES];

    // Stage 1 combinational inputs
    logic [WIDTH-1:0] x_in   [LANES];
    logic [WIDTH-1:0] ax_in  [LANES];
    logic [WIDTH:0]   a_in   [LANES];
    logic [LANES-1:0] neg_in;
    pwl_seg_e         seg_in [LANES];

    // Stage 2 combinational results
    logic [WIDTH-1:0]       sig_y [LANES];
    logic [LANES-1:0]       sig_sat;
    logic [WIDTH-1:0]       tanh_v [LANES];
    logic [LANES*WIDTH-1:0] pred_d;
    logic [LANES-1:0]       sat_d;

    assign s2_load   = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_load;
    assign out_valid = s2_valid;

    // |x| saturates the most-negative code to max positive. For Tanh the
    // sigmoid argument is 2x, so the stored magnitude is 2|x| (WIDTH+1 bits);
    // ReLU/Step never take that path, so their magnitude stays |x|.
    always_comb begin
        neg_in = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            x_in[i]   = in_sum[i*WIDTH +: WIDTH];
            neg_in[i] = x_in[i][WIDTH-1];
            if (x_in[i] == MOST_NEG)
                ax_in[i] = MOST_POS;
            else if (neg_in[i])
                ax_in[i] = -x_in[i];
            else
                ax_in[i] = x_in[i];
            a_in[i]   = (in_act == ACT_TANH) ? {ax_in[i], 1'b0} : {1'b0, ax_in[i]};
            seg_in[i] = pwl_classify(32'(a_in[i]), FRAC);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_act   <= ACT_SIGMOID;
            s1_neg   <= '0;
            for (int unsigned i = 0; i < LANES; i++) begin
                s1_a[i]   <= '0;
                s1_seg[i] <= SEG_LOW;
            end
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_act <= in_act;
                s1_neg <= neg_in;
                for (int unsigned i = 0; i < LANES; i++) begin
                    s1_a[i]   <= a_in[i];
                    s1_seg[i] <= seg_in[i];
                end
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        pwl_sigmoid_lane #(
            .WIDTH (WIDTH),
            .FRAC  (FRAC),
            .AW    (WIDTH + 1)
        ) u_lane (
            .a   (s1_a[g]),
            .neg (s1_neg[g]),
            .seg (s1_seg[g]),
            .y   (sig_y[g]),
            .sat (sig_sat[g])
        );
    end

    // Tanh = 2*sigmoid(2x) - ONE; magnitudes stay within +/-ONE so WIDTH-bit
    // wraparound arithmetic yields the exact two's-complement result.
    always_comb begin
        pred_d = '0;
        sat_d  = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            tanh_v[i] = (sig_y[i] << 1) - ONE_W;
            case (s1_act)
                ACT_SIGMOID: begin
                    pred_d[i*WIDTH +: WIDTH] = sig_y[i];
                    sat_d[i]                 = sig_sat[i];
                end
                ACT_TANH: begin
                    pred_d[i*WIDTH +: WIDTH] = tanh_v[i];
                    sat_d[i]                 = sig_sat[i];
                end
                ACT_RELU: begin
                    pred_d[i*WIDTH +: WIDTH] = s1_neg[i] ? {WIDTH{1'b0}} : s1_a[i][WIDTH-1:0];
                end
                default: begin
                    pred_d[i*WIDTH +: WIDTH] = (!s1_neg[i] && (s1_a[i] != '0)) ? ONE_W : {WIDTH{1'b0}};
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            out_pred <= '0;
            out_sat  <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_pred <= pred_d;
                out_sat  <= sat_d;
            end
        end
    end

endmodule

// File: tb/tb_act_pipe.sv
// Self-checking bench for act_pipe: directed vectors with literal
// expectations plus a scoreboard fed by a behavioural activation model.
module tb_act_pipe;
    import act_pipe_pkg::*;

    localparam int WIDTH = 16;
    localparam int FRAC  = 8;
    localparam int LANES = 4;
    localparam int W     = LANES * WIDTH;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    act_func          in_act;
    logic [W-1:0]     in_sum;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_pred;
    logic [LANES-1:0] out_sat;

    act_pipe #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC),
        .LANES (LANES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_act    (in_act),
        .in_sum    (in_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pred  (out_pred),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model (Q8.8 real-number rules) ----------
    function automatic int sig_model(input int x);
        int a;
        int y;
        a = (x < 0) ? -x : x;
        if (a >= 1280)      y = 256;            // >= 5.0
        else if (a >= 608)  y = a / 32 + 216;   // >= 2.375
        else if (a >= 256)  y = a / 8 + 160;    // >= 1.0
        else                y = a / 4 + 128;
        return (x < 0) ? 256 - y : y;
    endfunction

    function automatic bit sig_sat(input int x);
        return ((x < 0) ? -x : x) >= 1280;
    endfunction

    typedef struct packed {
        logic [W-1:0]     pred;
        logic [LANES-1:0] sat;
    } exp_t;

    function automatic exp_t model(input act_func f, input logic [W-1:0] s);
        exp_t e;
        logic signed [WIDTH-1:0] xs;
        int x;
        int p;
        bit st;
        e = '0;
        for (int i = 0; i < LANES; i++) begin
            xs = s[i*WIDTH +: WIDTH];
            x  = xs;
            st = 1'b0;
            case (f)
                ACT_SIGMOID: begin p = sig_model(x);         st = sig_sat(x);     end
                ACT_TANH:    begin p = 2*sig_model(2*x)-256; st = sig_sat(2*x);   end
                ACT_RELU:    p = (x > 0) ? x : 0;
                default:     p = (x > 0) ? 256 : 0;
            endcase
            e.pred[i*WIDTH +: WIDTH] = 16'(p);
            e.sat[i] = st;
        end
        return e;
    endfunction

    function automatic logic [W-1:0] pack4(input int l0, input int l1, input int l2, input int l3);
        logic [W-1:0] r;
        r[15:0]  = 16'(l0);
        r[31:16] = 16'(l1);
        r[47:32] = 16'(l2);
        r[63:48] = 16'(l3);
        return r;
    endfunction

    // ---------------- scoreboard / compare process ------------------------
    exp_t             exp_q[$];
    exp_t             mon_e;
    logic             prev_stall;
    logic [W-1:0]     prev_pred;
    logic [LANES-1:0] prev_sat;

    initial begin
        prev_stall = 1'b0;
        prev_pred  = '0;
        prev_sat   = '0;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                exp_q.delete();
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_hold_valid", out_valid, 1);
                    chk("stall_hold_pred", out_pred, prev_pred);
                    chk("stall_hold_sat", out_sat, prev_sat);
                end
                if (out_valid && out_ready) begin
                    chk("sb_nonempty", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        mon_e = exp_q.pop_front();
                        chk("sb_pred", out_pred, mon_e.pred);
                        chk("sb_sat", out_sat, mon_e.sat);
                    end
                end
                if (in_valid && in_ready)
                    exp_q.push_back(model(in_act, in_sum));
                prev_stall = out_valid && !out_ready;
                prev_pred  = out_pred;
                prev_sat   = out_sat;
            end
        end
    end

    // ---------------- stimulus helpers ------------------------------------
    // Starts at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input act_func f, input logic [W-1:0] s, output int waits);
        logic acc;
        in_valid = 1'b1;
        in_act   = f;
        in_sum   = s;
        waits    = 0;
        while (1) begin
            #4;
            acc = in_ready;
            @(negedge clk);
            if (acc) break;
            waits++;
            if (waits > 50) begin
                chk("push_timeout", 0, 1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [W-1:0] p, input logic [LANES-1:0] s);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_valid"}, out_valid, 1);
        chk({name, "_pred"}, out_pred, p);
        chk({name, "_sat"}, out_sat, s);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence -----------------------------------
    initial begin
        int w;
        int n;
        logic [W-1:0] held;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_act    = ACT_SIGMOID;
        in_sum    = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pred", out_pred, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        @(negedge clk);

        // Sigmoid with latency check: valid low one cycle, high the next
        push(ACT_SIGMOID, pack4(0, 256, -256, 1536), w);
        chk("sig_lat_early", out_valid, 0);
        @(negedge clk);
        chk("sig_lat_on_time", out_valid, 1);
        expect_out("sig", pack4(128, 192, 64, 256), 4'b1000);

        push(ACT_TANH, pack4(0, 128, -128, 1024), w);
        expect_out("tanh", pack4(0, 128, -128, 256), 4'b1000);

        push(ACT_RELU, pack4(-768, 300, 0, -32768), w);
        expect_out("relu", pack4(0, 300, 0, 0), 4'b0000);

        push(ACT_STEP, pack4(0, 1, -1, 32767), w);
        expect_out("step", pack4(0, 256, 0, 256), 4'b0000);

        // Segment boundaries 1.0 and 2.375
        push(ACT_SIGMOID, pack4(255, 256, 607, 608), w);
        expect_out("sig_bound", pack4(191, 192, 235, 235), 4'b0000);

        // Further boundaries through the scoreboard only
        push(ACT_SIGMOID, pack4(1279, 1280, -32768, 32767), w);
        push(ACT_SIGMOID, pack4(-607, -608, -1279, -1), w);
        push(ACT_TANH,    pack4(303, 304, 639, 640), w);
        push(ACT_TANH,    pack4(-32768, 32767, -1, 1), w);
        push(ACT_RELU,    pack4(32767, 1, -1, 0), w);
        push(ACT_STEP,    pack4(-32768, 2, 0, 32767), w);
        repeat (4) @(negedge clk);

        // Back-to-back stream of 8
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    push(act_func'(k % 4),
                         pack4(k*100 - 300, -k*37, k*200, 1000 - k*150), w);
                    chk("b2b_in_ready", w, 0);
                end
            end
            begin
                n = 0;
                while (!out_valid && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                for (int k = 0; k < 8; k++) begin
                    chk("b2b_consecutive", out_valid, 1);
                    @(negedge clk);
                end
            end
        join
        repeat (3) @(negedge clk);
        chk("b2b_drained", exp_q.size(), 0);

        // Stall: out_ready low for 5 cycles while a stream is offered
        out_ready = 1'b0;
        fork
            begin
                for (int k = 0; k < 6; k++)
                    push(ACT_SIGMOID, pack4(k*300, -k*300, k*50 + 7, 2000 - k*400), w);
            end
            begin
                repeat (5) @(negedge clk);
                chk("stall_in_ready", in_ready, 0);
                chk("stall_out_valid", out_valid, 1);
                chk("stall_occupancy", exp_q.size(), 2);
                held = out_pred;
                @(negedge clk);
                chk("stall_pred_stable", out_pred, held);
                out_ready = 1'b1;
            end
        join
        repeat (6) @(negedge clk);
        chk("stall_drained", exp_q.size(), 0);

        // Asynchronous reset with both stages full
        out_ready = 1'b0;
        push(ACT_RELU, pack4(500, 600, 700, 800), w);
        push(ACT_STEP, pack4(5, 6, 7, 8), w);
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_full", in_ready, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_pred", out_pred, 0);
        chk("arst_out_sat", out_sat, 0);
        chk("arst_in_ready", in_ready, 1);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        push(ACT_SIGMOID, pack4(-1536, 384, -100, 0), w);
        chk("post_rst_lat_early", out_valid, 0);
        @(negedge clk);
        chk("post_rst_lat_on_time", out_valid, 1);
        // 384 -> 48+160=208; -100 -> 256-(25+128)=103
        expect_out("post_rst", pack4(0, 208, 103, 128), 4'b0001);

        repeat (5) @(negedge clk);
        chk("final_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
